// File: rtl/seven_seg_scanner_if.sv
// ---------------------------------------------------------------------------
// seven_seg_scanner_if
//
// Groups the display-side signals of the seven-segment scanner.
//
//   display_data [31:0]  packed digit codes, [31:28]=AN7 ... [3:0]=AN0
//   blink_en     [7:0]   bit i=1: digit i blinks
//   dp_en        [7:0]   bit i=1: decimal point lit on digit i
//   an           [7:0]   anode enables, active-low, bit i = AN i
//   seg          [6:0]   cathodes, active-low, seg[0]=a ... seg[6]=g
//   dp                   decimal-point cathode, active-low
//   frame_done           one-cycle pulse at the end of every 8-digit frame
//
// master: the display controller side (drives digit data, watches outputs)
// slave : the scanner itself
// ---------------------------------------------------------------------------
interface seven_seg_scanner_if;
    logic [31:0] display_data;
    logic [7:0]  blink_en;
    logic [7:0]  dp_en;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    modport master (
        output display_data,
        output blink_en,
        output dp_en,
        input  an,
        input  seg,
        input  dp,
        input  frame_done
    );

    modport slave (
        input  display_data,
        input  blink_en,
        input  dp_en,
        output an,
        output seg,
        output dp,
        output frame_done
    );
endinterface

// File: rtl/seven_seg_scanner.sv
// ---------------------------------------------------------------------------
// seven_seg_scanner
//
// Time-multiplexed driver for an 8-digit common-anode seven-segment display.
// One digit is lit per refresh slot of REFRESH_DIV cycles. The first
// BLANK_CYCLES of every slot turn all anodes off so the previous digit's
// pattern never ghosts onto the next anode. Digit data, blink and dp enables
// are captured once per frame (prescaler==0, idx==0) so a frame is never torn.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    seven_seg_scanner_if.slave (display_data, blink_en, dp_en in;
//          an, seg, dp, frame_done out)
//
// All outputs are registered and lag the prescaler/idx state by one clock.
// ---------------------------------------------------------------------------
module seven_seg_scanner #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 2,
    parameter int BLINK_FRAMES = 125
) (
    input  logic                clk,
    input  logic                rst_n,
    seven_seg_scanner_if.slave  bus
);

    localparam int PRESC_W = $clog2(REFRESH_DIV);
    localparam int BCNT_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);
    localparam logic [PRESC_W-1:0] BLANK_END  = PRESC_W'(BLANK_CYCLES);
    localparam logic [BCNT_W-1:0]  BCNT_LAST  = BCNT_W'(BLINK_FRAMES - 1);

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // -----------------------------------------------------------------------
    // Segment decode, gfedcba, active-low. Code F is deliberately blank so a
    // controller can switch a digit off by writing F into its nibble.
    // -----------------------------------------------------------------------
    function automatic logic [6:0] decode(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Scan counters
    logic [PRESC_W-1:0] presc_reg, presc_next;
    logic [2:0]         idx_reg, idx_next;

    // Frame-synchronous shadow copies of the inputs
    logic [31:0] shadow_data_reg;
    logic [7:0]  shadow_blink_reg;
    logic [7:0]  shadow_dp_reg;

    // Blink state: hidden_reg=0 means digits are visible
    logic [BCNT_W-1:0] blink_cnt_reg, blink_cnt_next;
    logic              blink_hidden_reg, blink_hidden_next;

    // Registered outputs
    logic [7:0] an_reg, an_next;
    logic [6:0] seg_reg, seg_next;
    logic       dp_reg, dp_next;
    logic       frame_done_reg, frame_done_next;

    // Decoded per-digit views of the shadow and the scan position
    logic [3:0] nibble [8];
    logic [7:0] an_scan;

    logic slot_end;
    logic frame_start;
    logic frame_end;
    logic digit_hidden;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_digit
            assign nibble[gi]  = shadow_data_reg[gi*4 +: 4];
            assign an_scan[gi] = (idx_reg != 3'(gi));
        end
    endgenerate

    assign slot_end    = (presc_reg == PRESC_LAST);
    assign frame_end   = slot_end && (idx_reg == 3'd7);
    assign frame_start = (presc_reg == '0) && (idx_reg == 3'd0);
    assign digit_hidden = shadow_blink_reg[idx_reg] && blink_hidden_reg;

    // -----------------------------------------------------------------------
    // Next-state and next-output logic
    // -----------------------------------------------------------------------
    always_comb begin
        presc_next        = presc_reg + PRESC_W'(1);
        idx_next          = idx_reg;
        blink_cnt_next    = blink_cnt_reg;
        blink_hidden_next = blink_hidden_reg;
        an_next           = 8'hFF;
        seg_next          = SEG_OFF;
        dp_next           = 1'b1;
        frame_done_next   = frame_end;

        if (slot_end) begin
            presc_next = '0;
            idx_next   = idx_reg + 3'd1;
        end

        // The counter advances in the cycle frame_done is high, which is the
        // first cycle of the next frame; that cycle is always blanked, so the
        // new phase is seen cleanly from the next frame's first active slot.
        if (frame_done_reg) begin
            if (blink_cnt_reg == BCNT_LAST) begin
                blink_cnt_next    = '0;
                blink_hidden_next = ~blink_hidden_reg;
            end else begin
                blink_cnt_next = blink_cnt_reg + BCNT_W'(1);
            end
        end

        if (presc_reg >= BLANK_END) begin
            an_next = an_scan;
            if (!digit_hidden) begin
                seg_next = decode(nibble[idx_reg]);
                dp_next  = ~shadow_dp_reg[idx_reg];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Scan counters and blink state
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_reg        <= '0;
            idx_reg          <= 3'd0;
            blink_cnt_reg    <= '0;
            blink_hidden_reg <= 1'b0;
        end else begin
            presc_reg        <= presc_next;
            idx_reg          <= idx_next;
            blink_cnt_reg    <= blink_cnt_next;
            blink_hidden_reg <= blink_hidden_next;
        end
    end

    // -----------------------------------------------------------------------
    // Shadow latch. Loaded only at the frame boundary; that cycle's output is
    // blanked (BLANK_CYCLES >= 1), so the freshly loaded word is in place
    // before the first lit cycle of AN0.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_data_reg  <= 32'hFFFF_FFFF;
            shadow_blink_reg <= 8'h00;
            shadow_dp_reg    <= 8'h00;
        end else if (frame_start) begin
            shadow_data_reg  <= bus.display_data;
            shadow_blink_reg <= bus.blink_en;
            shadow_dp_reg    <= bus.dp_en;
        end
    end

    // -----------------------------------------------------------------------
    // Output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_reg         <= 8'hFF;
            seg_reg        <= SEG_OFF;
            dp_reg         <= 1'b1;
            frame_done_reg <= 1'b0;
        end else begin
            an_reg         <= an_next;
            seg_reg        <= seg_next;
            dp_reg         <= dp_next;
            frame_done_reg <= frame_done_next;
        end
    end

    assign bus.an         = an_reg;
    assign bus.seg        = seg_reg;
    assign bus.dp         = dp_reg;
    assign bus.frame_done = frame_done_reg;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// ---------------------------------------------------------------------------
// tb_seven_seg_scanner
//
// Directed bench for seven_seg_scanner with REFRESH_DIV=8, BLANK_CYCLES=2,
// BLINK_FRAMES=2. cyc counts rising edges since reset release; outputs are
// sampled on the falling edge. Output at cyc=k reflects counter state k-1,
// so slot = (k-1)/8 mod 8 and slot position p = (k-1) mod 8.
// ---------------------------------------------------------------------------
module tb_seven_seg_scanner;

    localparam int RDIV  = 8;
    localparam int BLANK = 2;
    localparam int BFR   = 2;

    localparam logic [6:0] S_0   = 7'b1000000;
    localparam logic [6:0] S_1   = 7'b1111001;
    localparam logic [6:0] S_2   = 7'b0100100;
    localparam logic [6:0] S_3   = 7'b0110000;
    localparam logic [6:0] S_4   = 7'b0011001;
    localparam logic [6:0] S_5   = 7'b0010010;
    localparam logic [6:0] S_6   = 7'b0000010;
    localparam logic [6:0] S_7   = 7'b1111000;
    localparam logic [6:0] S_8   = 7'b0000000;
    localparam logic [6:0] S_C   = 7'b1000110;
    localparam logic [6:0] S_D   = 7'b0100001;
    localparam logic [6:0] S_E   = 7'b0000110;
    localparam logic [6:0] S_OFF = 7'h7F;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seven_seg_scanner_if bus_if ();

    seven_seg_scanner #(
        .REFRESH_DIV  (RDIV),
        .BLANK_CYCLES (BLANK),
        .BLINK_FRAMES (BFR)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    function automatic logic [7:0] scan_an(input int k);
        logic [7:0] one;
        int slot;
        one  = 8'h01;
        slot = ((k - 1) / RDIV) % 8;
        if (((k - 1) % RDIV) < BLANK) return 8'hFF;
        return ~(one << slot);
    endfunction

    // -----------------------------------------------------------------------
    task automatic test_reset();
        bus_if.display_data = 32'hFFFF_FF00;
        bus_if.blink_en     = 8'h00;
        bus_if.dp_en        = 8'h00;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus_if.an !== 8'hFF) begin
            n_fail++; $display("FAIL reset_an got=%h exp=ff", bus_if.an);
        end
        n_checks++;
        if (bus_if.seg !== S_OFF) begin
            n_fail++; $display("FAIL reset_seg got=%b exp=%b", bus_if.seg, S_OFF);
        end
        n_checks++;
        if (bus_if.dp !== 1'b1) begin
            n_fail++; $display("FAIL reset_dp got=%b exp=1", bus_if.dp);
        end
        n_checks++;
        if (bus_if.frame_done !== 1'b0) begin
            n_fail++; $display("FAIL reset_frame_done got=%b exp=0", bus_if.frame_done);
        end
        $display("test_reset: outputs held blank during reset");
    endtask

    // -----------------------------------------------------------------------
    task automatic test_scan();
        int p, slot;
        logic [6:0] exp_seg;
        bus_if.display_data = 32'hFFFF_FF00;
        do_reset();
        for (int i = 0; i < 64; i++) begin
            step();
            p    = (cyc - 1) % RDIV;
            slot = (cyc - 1) / RDIV;
            exp_seg = (p < BLANK || slot > 1) ? S_OFF : S_0;
            n_checks++;
            if (bus_if.an !== scan_an(cyc)) begin
                n_fail++; $display("FAIL scan_an cyc=%0d got=%h exp=%h", cyc, bus_if.an, scan_an(cyc));
            end
            n_checks++;
            if (bus_if.seg !== exp_seg) begin
                n_fail++; $display("FAIL scan_seg cyc=%0d got=%b exp=%b", cyc, bus_if.seg, exp_seg);
            end
            n_checks++;
            if (bus_if.dp !== 1'b1) begin
                n_fail++; $display("FAIL scan_dp cyc=%0d got=%b exp=1", cyc, bus_if.dp);
            end
            n_checks++;
            if (bus_if.frame_done !== (cyc == 64)) begin
                n_fail++; $display("FAIL scan_frame_done cyc=%0d got=%b exp=%b", cyc, bus_if.frame_done, cyc == 64);
            end
        end
        $display("test_scan: one frame of FFFFFF00 scanned");
    endtask

    // -----------------------------------------------------------------------
    task automatic test_frame_latch();
        logic [6:0] f1 [8];
        logic [6:0] f2 [8];
        logic [6:0] exp_seg;
        int p, slot, frame;
        f1 = '{S_5, S_0, S_OFF, S_OFF, S_OFF, S_OFF, S_D, S_C};
        f2 = '{S_8, S_7, S_6, S_5, S_4, S_3, S_2, S_1};
        bus_if.display_data = 32'hCDFF_FF05;
        do_reset();
        for (int i = 0; i < 128; i++) begin
            step();
            if (cyc == 20) bus_if.display_data = 32'h1234_5678;
            p     = (cyc - 1) % RDIV;
            slot  = ((cyc - 1) / RDIV) % 8;
            frame = (cyc - 1) / 64;
            if (p < BLANK)       exp_seg = S_OFF;
            else if (frame == 0) exp_seg = f1[slot];
            else                 exp_seg = f2[slot];
            n_checks++;
            if (bus_if.seg !== exp_seg) begin
                n_fail++; $display("FAIL latch_seg cyc=%0d slot=%0d got=%b exp=%b", cyc, slot, bus_if.seg, exp_seg);
            end
            n_checks++;
            if (bus_if.an !== scan_an(cyc)) begin
                n_fail++; $display("FAIL latch_an cyc=%0d got=%h exp=%h", cyc, bus_if.an, scan_an(cyc));
            end
        end
        $display("test_frame_latch: mid-frame change deferred to next frame");
    endtask

    // -----------------------------------------------------------------------
    task automatic test_frame_done();
        int pulses;
        pulses = 0;
        bus_if.display_data = 32'h0123_4567;
        do_reset();
        for (int i = 0; i < 192; i++) begin
            step();
            if (bus_if.frame_done === 1'b1) pulses++;
            n_checks++;
            if (bus_if.frame_done !== ((cyc % 64) == 0)) begin
                n_fail++; $display("FAIL fd_pulse cyc=%0d got=%b exp=%b", cyc, bus_if.frame_done, (cyc % 64) == 0);
            end
            n_checks++;
            if ($countones(~bus_if.an) > 1) begin
                n_fail++; $display("FAIL fd_onehot cyc=%0d got=%h exp=at most one low bit", cyc, bus_if.an);
            end
            if (((cyc - 1) % RDIV) < BLANK) begin
                n_checks++;
                if (bus_if.an !== 8'hFF) begin
                    n_fail++; $display("FAIL fd_blank cyc=%0d got=%h exp=ff", cyc, bus_if.an);
                end
            end
        end
        n_checks++;
        if (pulses != 3) begin
            n_fail++; $display("FAIL fd_count got=%0d exp=3", pulses);
        end
        $display("test_frame_done: %0d pulses over 3 frames", pulses);
    endtask

    // -----------------------------------------------------------------------
    task automatic test_blink();
        int p, slot, frame;
        logic [6:0] exp_seg;
        bus_if.display_data = 32'hFFFF_FF88;
        bus_if.blink_en     = 8'h01;
        do_reset();
        for (int i = 0; i < 256; i++) begin
            step();
            p     = (cyc - 1) % RDIV;
            slot  = ((cyc - 1) / RDIV) % 8;
            frame = (cyc - 1) / 64 + 1;
            if (p < BLANK)                   exp_seg = S_OFF;
            else if (slot == 0)              exp_seg = (frame <= 2) ? S_8 : S_OFF;
            else if (slot == 1)              exp_seg = S_8;
            else                             exp_seg = S_OFF;
            n_checks++;
            if (bus_if.seg !== exp_seg) begin
                n_fail++; $display("FAIL blink_seg cyc=%0d frame=%0d slot=%0d got=%b exp=%b", cyc, frame, slot, bus_if.seg, exp_seg);
            end
            n_checks++;
            if (bus_if.an !== scan_an(cyc)) begin
                n_fail++; $display("FAIL blink_an cyc=%0d got=%h exp=%h", cyc, bus_if.an, scan_an(cyc));
            end
        end
        bus_if.blink_en = 8'h00;
        $display("test_blink: 4 frames with AN0 blinking");
    endtask

    // -----------------------------------------------------------------------
    task automatic test_dp();
        logic [6:0] tbl [8];
        logic [6:0] exp_seg;
        logic       exp_dp;
        int p, slot;
        tbl = '{S_2, S_1, S_OFF, S_OFF, S_OFF, S_E, S_E, S_E};
        bus_if.display_data = 32'hEEEF_FF12;
        bus_if.dp_en        = 8'h04;
        do_reset();
        for (int i = 0; i < 64; i++) begin
            step();
            p      = (cyc - 1) % RDIV;
            slot   = (cyc - 1) / RDIV;
            exp_seg = (p < BLANK) ? S_OFF : tbl[slot];
            exp_dp  = !(p >= BLANK && slot == 2);
            n_checks++;
            if (bus_if.dp !== exp_dp) begin
                n_fail++; $display("FAIL dp_dp cyc=%0d got=%b exp=%b", cyc, bus_if.dp, exp_dp);
            end
            n_checks++;
            if (bus_if.seg !== exp_seg) begin
                n_fail++; $display("FAIL dp_seg cyc=%0d got=%b exp=%b", cyc, bus_if.seg, exp_seg);
            end
        end
        bus_if.dp_en = 8'h00;
        $display("test_dp: decimal point on digit 2");
    endtask

    // -----------------------------------------------------------------------
    task automatic test_async_reset();
        bus_if.display_data = 32'h1111_1111;
        bus_if.dp_en        = 8'hFF;
        do_reset();
        repeat (44) step();
        n_checks++;
        if (bus_if.an !== 8'hDF || bus_if.seg !== S_1 || bus_if.dp !== 1'b0) begin
            n_fail++; $display("FAIL areset_pre got=%h/%b/%b exp=df/%b/0", bus_if.an, bus_if.seg, bus_if.dp, S_1);
        end
        #2;
        rst_n = 1'b0;
        bus_if.display_data = 32'h0000_0003;
        bus_if.dp_en        = 8'h00;
        #1;
        n_checks++;
        if (bus_if.an !== 8'hFF) begin
            n_fail++; $display("FAIL areset_an got=%h exp=ff", bus_if.an);
        end
        n_checks++;
        if (bus_if.seg !== S_OFF) begin
            n_fail++; $display("FAIL areset_seg got=%b exp=%b", bus_if.seg, S_OFF);
        end
        n_checks++;
        if (bus_if.dp !== 1'b1) begin
            n_fail++; $display("FAIL areset_dp got=%b exp=1", bus_if.dp);
        end
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step();
            n_checks++;
            if (bus_if.an !== scan_an(cyc)) begin
                n_fail++; $display("FAIL areset_scan_an cyc=%0d got=%h exp=%h", cyc, bus_if.an, scan_an(cyc));
            end
            if (cyc == 3) begin
                n_checks++;
                if (bus_if.seg !== S_3) begin
                    n_fail++; $display("FAIL areset_seg0 got=%b exp=%b", bus_if.seg, S_3);
                end
            end
            if (cyc == 11) begin
                n_checks++;
                if (bus_if.seg !== S_0) begin
                    n_fail++; $display("FAIL areset_seg1 got=%b exp=%b", bus_if.seg, S_0);
                end
            end
        end
        $display("test_async_reset: mid-slot reset and restart at AN0");
    endtask

    initial begin
        test_reset();
        test_scan();
        test_frame_latch();
        test_frame_done();
        test_blink();
        test_dp();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
- Time-multiplexed driver for the board's 8-digit common-anode seven-segment display.
- Consumes the 32-bit packed nibble word from the display controller (nibble 7 = AN7 ... nibble 0 = AN0).
- Scans one digit per refresh slot, decodes each nibble to segments, and drives active-low anodes and cathodes.
- Adds frame-synchronous latching (no tearing), anti-ghost blanking, per-digit blink and decimal-point control.

Parameters:
REFRESH_DIV, 100000, clk cycles per digit slot (1 kHz slot rate at 100 MHz); legal range 4 or more.
BLANK_CYCLES, 2, cycles at the start of each slot with all anodes off; legal range 1 to REFRESH_DIV-1.
BLINK_FRAMES, 125, full frames per blink half-period; legal range 1 or more.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
display_data  in  32  packed digit codes, [31:28]=AN7 ... [3:0]=AN0
blink_en  in  8  bit i=1: digit i blinks
dp_en  in  8  bit i=1: decimal point lit on digit i
an  out  8  anode enables, active-low, bit i = AN i
seg  out  7  cathodes, active-low, seg[0]=a ... seg[6]=g
dp  out  1  decimal-point cathode, active-low
frame_done  out  1  one-cycle pulse at the end of every 8-digit frame

Behaviour:
- Reset (async, rst_n=0) values:
  - an=8'hFF, seg=7'h7F, dp=1, frame_done=0
  - prescaler=0, digit index idx=0
  - shadow=32'hFFFFFFFF, blink phase=visible, blink counter=0
- Prescaler:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - On wrap, idx increments 0..7, wrapping 7->0.
- Shadow latch:
  - Loads display_data, blink_en and dp_en on every cycle with prescaler==0 and idx==0.
  - This includes the first cycle after reset release.
  - Input changes mid-frame have no effect until the next frame boundary.
- Output registering:
  - an, seg and dp are registered from the current prescaler, idx, shadow and blink phase.
  - Outputs therefore lag counter state by exactly 1 clk.
- Anti-ghost: while prescaler < BLANK_CYCLES, next an=8'hFF, seg=7'h7F, dp=1.
- Active portion of a slot:
  - an has only bit idx low.
  - seg = decode(shadow nibble idx).
  - dp = ~dp_en_shadow[idx].
- Decode table (gfedcba, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - A=0001000, b=0000011, C=1000110, d=0100001, E=0000110
  - F=blank 1111111 (code F never lights segments)
- Blink:
  - If blink_en_shadow[idx]=1 and phase=hidden, seg=7'h7F and dp=1.
  - an still scans normally during the hidden phase, so timing stays uniform.
- frame_done:
  - Registered; high for exactly one cycle, the cycle after prescaler==REFRESH_DIV-1 with idx==7.
  - Coincides with the cycle in which the shadow reloads.
- Blink counter:
  - Increments on each frame_done event, counting 0..BLINK_FRAMES-1.
  - On wrap, it returns to 0 and the phase toggles.
  - Phase is evaluated against the current value, so the new phase is first shown in the following frame.
- Simultaneous events: the frame wrap, shadow load and blink counter update occur in the same cycle with no priority conflict.
- Reset mid-slot or mid-frame: outputs blank immediately (asynchronous), and scanning restarts at AN0 with a fresh latch after release.
- Unknown or X inputs are never latched outside the frame boundary.

Test Plan:
All scenarios use REFRESH_DIV=8, BLANK_CYCLES=2, BLINK_FRAMES=2.
- Reset then hold display_data=32'hFFFFFF00:
  - Slot 0 (2 blank cycles) gives an=FE, seg=1000000 for 6 cycles.
  - Slot 1 is identical with an=FD.
  - Slots 2-7 give an=FB..7F with seg=7F.
  - Slot 0 begins at cycle 1 after reset release.
- Apply display_data=32'hCDFFFF05, then change it to 32'h12345678 mid-frame:
  - The current frame still shows C,d,blank...,0,5.
  - The new word appears only after frame_done.
  - Check C=1000110, d=0100001.
- Measure frame_done over 3 frames:
  - Exactly one-cycle pulses, period 64 cycles.
  - an never has more than one bit low.
  - During the first 2 cycles of every slot, an=FF.
- Apply blink_en=8'h01 with display_data=32'hFFFFFF88:
  - AN0 shows 0000000 for frames 1-2 and blank for frames 3-4.
  - AN1 shows 0000000 continuously.
  - an scanning continues unchanged throughout.
- Apply dp_en=8'h04 with display_data=32'hEEEFFF12:
  - dp=0 only during the active part of slot 2 (where seg=7F, blank digit, dot lit).
  - dp=1 elsewhere.
  - AN7..AN5 show E=0000110.
- Assert rst_n=0 during slot 5:
  - an=FF, seg=7F and dp=1 asynchronously, before the next clk edge.
  - After release, AN0 is scanned first with freshly latched data.
